// File: rtl/mem_stage_pipe.sv
// Execute-to-writeback memory stage: registers the X/M boundary, drives a req/ack data-memory
// port with store lane steering and load extension, and stalls upstream during accesses.
module mem_stage_pipe #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_x,
  input  logic [31:0] inst_x,
  input  logic [31:0] PC_x,
  input  logic [31:0] alu_x,
  input  logic [31:0] rs2_x,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_m,
  output logic [31:0] inst_m,
  output logic [31:0] PC_m,
  output logic [31:0] wb_m,
  output logic [4:0]  rd_m,
  output logic        regwe_m,
  output logic        err_m
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic {StRun, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     pend_inst_q;
  logic [31:0]     pend_pc_q;
  logic [1:0]      pend_off_q;

  // Execute-side decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem;
  logic        legal_f3, aligned, mem_ok;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] alu_wb;
  logic        alu_regwe;

  always_comb begin
    opcode   = inst_x[6:0];
    funct3   = inst_x[14:12];
    is_load  = (opcode == OpLoad);
    is_store = (opcode == OpStore);
    is_mem   = is_load | is_store;

    legal_f3 = 1'b0;
    if (is_load) begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (is_store) begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end

    // funct3[1:0] encodes access size for both loads and stores
    lane_be    = 4'b0000;
    lane_wdata = rs2_x;
    aligned    = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        aligned    = 1'b1;
        lane_be    = 4'b0001 << alu_x[1:0];
        lane_wdata = {4{rs2_x[7:0]}};
      end
      2'b01: begin
        aligned    = ~alu_x[0];
        lane_be    = alu_x[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{rs2_x[15:0]}};
      end
      2'b10: begin
        aligned    = (alu_x[1:0] == 2'b00);
        lane_be    = 4'b1111;
        lane_wdata = rs2_x;
      end
      default: aligned = 1'b0;
    endcase
    mem_ok = legal_f3 & aligned;

    alu_wb    = ((opcode == OpJal) || (opcode == OpJalr)) ? (PC_x + 32'd4) : alu_x;
    alu_regwe = !((opcode == OpBranch) || (opcode == OpFence) || (opcode == OpSystem)) &&
                (inst_x[11:7] != 5'd0);
  end

  // Load data extraction from the returned word
  logic [2:0]  pend_f3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    pend_f3 = pend_inst_q[14:12];
    ld_byte = dmem_rdata[7:0];
    case (pend_off_q)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = pend_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (pend_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  assign stall_m = (state_q == StWait);
  assign rd_m    = inst_m[11:7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      pend_inst_q <= NOP_INST;
      pend_pc_q   <= 32'd0;
      pend_off_q  <= 2'b00;
      valid_m     <= 1'b0;
      inst_m      <= NOP_INST;
      PC_m        <= 32'd0;
      wb_m        <= 32'd0;
      regwe_m     <= 1'b0;
      err_m       <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_be     <= 4'b0000;
      dmem_wdata  <= 32'd0;
    end else begin
      case (state_q)
        StRun: begin
          if (!valid_x) begin
            valid_m <= 1'b0;
            inst_m  <= NOP_INST;
            regwe_m <= 1'b0;
            err_m   <= 1'b0;
          end else if (is_mem && mem_ok) begin
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= {alu_x[31:2], 2'b00};
            dmem_be     <= lane_be;
            dmem_wdata  <= lane_wdata;
            pend_inst_q <= inst_x;
            pend_pc_q   <= PC_x;
            pend_off_q  <= alu_x[1:0];
            cnt_q       <= '0;
            valid_m     <= 1'b0;
            inst_m      <= NOP_INST;
            regwe_m     <= 1'b0;
            err_m       <= 1'b0;
            state_q     <= StWait;
          end else if (is_mem) begin
            // Misaligned or illegal access retires immediately as an error
            valid_m <= 1'b1;
            inst_m  <= inst_x;
            PC_m    <= PC_x;
            wb_m    <= 32'd0;
            regwe_m <= 1'b0;
            err_m   <= 1'b1;
          end else begin
            valid_m <= 1'b1;
            inst_m  <= inst_x;
            PC_m    <= PC_x;
            wb_m    <= alu_wb;
            regwe_m <= alu_regwe;
            err_m   <= 1'b0;
          end
        end
        StWait: begin
          if (dmem_ack) begin
            valid_m  <= 1'b1;
            inst_m   <= pend_inst_q;
            PC_m     <= pend_pc_q;
            err_m    <= 1'b0;
            wb_m     <= dmem_we ? 32'd0 : ld_val;
            regwe_m  <= !dmem_we && (pend_inst_q[11:7] != 5'd0);
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'b0000;
            state_q  <= StRun;
          end else if (cnt_q == CntMax) begin
            valid_m  <= 1'b1;
            inst_m   <= pend_inst_q;
            PC_m     <= pend_pc_q;
            wb_m     <= 32'd0;
            regwe_m  <= 1'b0;
            err_m    <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'b0000;
            state_q  <= StRun;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
            valid_m <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
